lite_bus_arbiter: RTL and testbench

LITE_BUS_ARBITER -- requirements
Module: lite_bus_arbiter

---
 rtl/lite_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_lite_bus_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lite_bus_arbiter.sv
// Two-requester arbiter onto a lite user bus; one command in flight, accept-to-bus 1 cycle, done 1 cycle after last handshake.
// Backpressure: cmd_ready only in IDLE for the round-robin winner; waits indefinitely on awready/wready/arready/rvalid.
module lite_bus_arbiter #(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESET,

    input  logic                      s0_cmd_valid,
    input  logic                      s0_cmd_write,
    input  logic [C_ADDR_WIDTH-1:0]   s0_cmd_addr,
    input  logic [C_DATA_WIDTH-1:0]   s0_cmd_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] s0_cmd_wstrb,
    output logic                      s0_cmd_ready,
    output logic                      s0_done,
    output logic [C_DATA_WIDTH-1:0]   s0_rdata,

    input  logic                      s1_cmd_valid,
    input  logic                      s1_cmd_write,
    input  logic [C_ADDR_WIDTH-1:0]   s1_cmd_addr,
    input  logic [C_DATA_WIDTH-1:0]   s1_cmd_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] s1_cmd_wstrb,
    output logic                      s1_cmd_ready,
    output logic                      s1_done,
    output logic [C_DATA_WIDTH-1:0]   s1_rdata,

    output logic [C_ADDR_WIDTH-1:0]   awaddr,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [C_DATA_WIDTH-1:0]   wdata,
    output logic [C_DATA_WIDTH/8-1:0] wstrb,
    output logic                      wvalid,
    input  logic                      wready,
    output logic [C_ADDR_WIDTH-1:0]   araddr,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [C_DATA_WIDTH-1:0]   rdata,
    input  logic                      rvalid,
    output logic                      rready
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_ADDR = 2'd2,
        READ_DATA = 2'd3
    } state_t;

    state_t state;
    logic   last_grant;
    logic   owner;

    logic                      grant0;
    logic                      grant1;
    logic                      accept;
    logic                      cmd_write;
    logic [C_ADDR_WIDTH-1:0]   cmd_addr;
    logic [C_DATA_WIDTH-1:0]   cmd_wdata;
    logic [C_DATA_WIDTH/8-1:0] cmd_wstrb;
    logic                      aw_fin;
    logic                      w_fin;

    // On a tie the requester that did not win last time goes; the two grants are mutually exclusive.
    assign grant0 = s0_cmd_valid && (!s1_cmd_valid || last_grant);
    assign grant1 = s1_cmd_valid && (!s0_cmd_valid || !last_grant);

    assign s0_cmd_ready = (state == IDLE) && !ARESET && grant0;
    assign s1_cmd_ready = (state == IDLE) && !ARESET && grant1;
    assign accept       = s0_cmd_ready || s1_cmd_ready;

    assign cmd_write = grant1 ? s1_cmd_write : s0_cmd_write;
    assign cmd_addr  = grant1 ? s1_cmd_addr  : s0_cmd_addr;
    assign cmd_wdata = grant1 ? s1_cmd_wdata : s0_cmd_wdata;
    assign cmd_wstrb = grant1 ? s1_cmd_wstrb : s0_cmd_wstrb;

    // A channel is finished once its valid has dropped or its handshake completes this edge.
    assign aw_fin = !awvalid || awready;
    assign w_fin  = !wvalid  || wready;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            awaddr     <= '0;
            awvalid    <= 1'b0;
            wdata      <= '0;
            wstrb      <= '0;
            wvalid     <= 1'b0;
            araddr     <= '0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            s0_done    <= 1'b0;
            s1_done    <= 1'b0;
            s0_rdata   <= '0;
            s1_rdata   <= '0;
        end else begin
            s0_done <= 1'b0;
            s1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= grant1;
                        last_grant <= grant1;
                        if (cmd_write) begin
                            awaddr  <= cmd_addr;
                            wdata   <= cmd_wdata;
                            wstrb   <= cmd_wstrb;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WRITE;
                        end else begin
                            araddr  <= cmd_addr;
                            arvalid <= 1'b1;
                            state   <= READ_ADDR;
                        end
                    end
                end
                WRITE: begin
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                    end
                    if (aw_fin && w_fin) begin
                        s0_done <= !owner;
                        s1_done <= owner;
                        state   <= IDLE;
                    end
                end
                READ_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= READ_DATA;
                    end
                end
                READ_DATA: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        if (owner) begin
                            s1_rdata <= rdata;
                        end else begin
                            s0_rdata <= rdata;
                        end
                        s0_done <= !owner;
                        s1_done <= owner;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lite_bus_arbiter.sv
// Bench for lite_bus_arbiter: directed scenarios followed by a randomized run against a transaction-level model.
module tb_lite_bus_arbiter;

    logic        ACLK;
    logic        ARESET;
    logic        s0_cmd_valid, s0_cmd_write, s0_cmd_ready, s0_done;
    logic [31:0] s0_cmd_addr, s0_cmd_wdata, s0_rdata;
    logic [3:0]  s0_cmd_wstrb;
    logic        s1_cmd_valid, s1_cmd_write, s1_cmd_ready, s1_done;
    logic [31:0] s1_cmd_addr, s1_cmd_wdata, s1_rdata;
    logic [3:0]  s1_cmd_wstrb;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } cmd_t;

    lite_bus_arbiter #(.C_ADDR_WIDTH(32), .C_DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s0_cmd_valid(s0_cmd_valid), .s0_cmd_write(s0_cmd_write), .s0_cmd_addr(s0_cmd_addr),
        .s0_cmd_wdata(s0_cmd_wdata), .s0_cmd_wstrb(s0_cmd_wstrb), .s0_cmd_ready(s0_cmd_ready),
        .s0_done(s0_done), .s0_rdata(s0_rdata),
        .s1_cmd_valid(s1_cmd_valid), .s1_cmd_write(s1_cmd_write), .s1_cmd_addr(s1_cmd_addr),
        .s1_cmd_wdata(s1_cmd_wdata), .s1_cmd_wstrb(s1_cmd_wstrb), .s1_cmd_ready(s1_cmd_ready),
        .s1_done(s1_done), .s1_rdata(s1_rdata),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_inputs();
        s0_cmd_valid = 0; s0_cmd_write = 0; s0_cmd_addr = 0; s0_cmd_wdata = 0; s0_cmd_wstrb = 0;
        s1_cmd_valid = 0; s1_cmd_write = 0; s1_cmd_addr = 0; s1_cmd_wdata = 0; s1_cmd_wstrb = 0;
        awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        ARESET = 1'b0;
        #1;
        ARESET = 1'b1;
        s0_cmd_valid = 1'b1;
        #1;
        chk_cnt++; if ({awvalid, wvalid, arvalid, rready} !== 4'b0) $display("FAIL rst_valids: got %b want 0000", {awvalid, wvalid, arvalid, rready}); else pass_cnt++;
        chk_cnt++; if ({s0_done, s1_done} !== 2'b00) $display("FAIL rst_done: got %b want 00", {s0_done, s1_done}); else pass_cnt++;
        chk_cnt++; if ({s0_rdata, s1_rdata} !== 64'h0) $display("FAIL rst_rdata: got %h want 0", {s0_rdata, s1_rdata}); else pass_cnt++;
        chk_cnt++; if ({awaddr, araddr, wdata, wstrb} !== 100'h0) $display("FAIL rst_busregs: got %h want 0", {awaddr, araddr, wdata, wstrb}); else pass_cnt++;
        chk_cnt++; if (s0_cmd_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", s0_cmd_ready); else pass_cnt++;
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        s0_cmd_valid = 1'b0;
    endtask

    task automatic test_write_basic();
        s0_cmd_valid = 1; s0_cmd_write = 1; s0_cmd_addr = 32'h10; s0_cmd_wdata = 32'hDEADBEEF; s0_cmd_wstrb = 4'hF;
        awready = 1; wready = 1;
        #1;
        chk_cnt++; if (s0_cmd_ready !== 1'b1) $display("FAIL wb_ready0: got %b want 1", s0_cmd_ready); else pass_cnt++;
        chk_cnt++; if (s1_cmd_ready !== 1'b0) $display("FAIL wb_ready1: got %b want 0", s1_cmd_ready); else pass_cnt++;
        chk_cnt++; if (awvalid !== 1'b0) $display("FAIL wb_aw_c0: got %b want 0", awvalid); else pass_cnt++;
        tick();
        s0_cmd_valid = 0; s0_cmd_addr = 32'hFFFF_0000; s0_cmd_wdata = 32'h0;
        chk_cnt++; if ({awvalid, wvalid} !== 2'b11) $display("FAIL wb_valids_c1: got %b want 11", {awvalid, wvalid}); else pass_cnt++;
        chk_cnt++; if (awaddr !== 32'h10) $display("FAIL wb_awaddr: got %h want 00000010", awaddr); else pass_cnt++;
        chk_cnt++; if (wdata !== 32'hDEADBEEF) $display("FAIL wb_wdata: got %h want deadbeef", wdata); else pass_cnt++;
        chk_cnt++; if (wstrb !== 4'hF) $display("FAIL wb_wstrb: got %h want f", wstrb); else pass_cnt++;
        chk_cnt++; if (s0_done !== 1'b0) $display("FAIL wb_done_c1: got %b want 0", s0_done); else pass_cnt++;
        tick();
        chk_cnt++; if ({s0_done, s1_done} !== 2'b10) $display("FAIL wb_done_c2: got %b want 10", {s0_done, s1_done}); else pass_cnt++;
        chk_cnt++; if ({awvalid, wvalid} !== 2'b00) $display("FAIL wb_valids_c2: got %b want 00", {awvalid, wvalid}); else pass_cnt++;
        tick();
        chk_cnt++; if (s0_done !== 1'b0) $display("FAIL wb_done_c3: got %b want 0", s0_done); else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_write_split();
        s0_cmd_valid = 1; s0_cmd_write = 1; s0_cmd_addr = 32'h44; s0_cmd_wdata = 32'hCAFEF00D; s0_cmd_wstrb = 4'h3;
        #1;
        chk_cnt++; if (s0_cmd_ready !== 1'b1) $display("FAIL ws_ready: got %b want 1", s0_cmd_ready); else pass_cnt++;
        tick();
        s0_cmd_valid = 0; s0_cmd_wdata = 32'h1;
        chk_cnt++; if ({awvalid, wvalid} !== 2'b11) $display("FAIL ws_valids_c1: got %b want 11", {awvalid, wvalid}); else pass_cnt++;
        tick();
        awready = 1;
        chk_cnt++; if (awvalid !== 1'b1) $display("FAIL ws_aw_c2: got %b want 1", awvalid); else pass_cnt++;
        tick();
        awready = 0;
        chk_cnt++; if ({awvalid, wvalid, s0_done} !== 3'b010) $display("FAIL ws_c3: got %b want 010", {awvalid, wvalid, s0_done}); else pass_cnt++;
        tick();
        awready = 1;
        chk_cnt++; if ({awvalid, wvalid, s0_done} !== 3'b010) $display("FAIL ws_c4: got %b want 010", {awvalid, wvalid, s0_done}); else pass_cnt++;
        tick();
        wready = 1;
        chk_cnt++; if ({awvalid, wvalid, s0_done} !== 3'b010) $display("FAIL ws_c5: got %b want 010", {awvalid, wvalid, s0_done}); else pass_cnt++;
        chk_cnt++; if ({wdata, wstrb} !== {32'hCAFEF00D, 4'h3}) $display("FAIL ws_wdata_hold: got %h want cafef00d3", {wdata, wstrb}); else pass_cnt++;
        tick();
        wready = 0; awready = 0;
        chk_cnt++; if ({wvalid, s0_done} !== 2'b01) $display("FAIL ws_c6: got %b want 01", {wvalid, s0_done}); else pass_cnt++;
        tick();
        chk_cnt++; if (s0_done !== 1'b0) $display("FAIL ws_c7_single_done: got %b want 0", s0_done); else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_read();
        s1_cmd_valid = 1; s1_cmd_write = 0; s1_cmd_addr = 32'h20;
        #1;
        chk_cnt++; if ({s0_cmd_ready, s1_cmd_ready} !== 2'b01) $display("FAIL rd_ready: got %b want 01", {s0_cmd_ready, s1_cmd_ready}); else pass_cnt++;
        tick();
        s1_cmd_valid = 0; s1_cmd_addr = 32'h0; arready = 1;
        chk_cnt++; if ({arvalid, rready} !== 2'b10) $display("FAIL rd_c1: got %b want 10", {arvalid, rready}); else pass_cnt++;
        chk_cnt++; if (araddr !== 32'h20) $display("FAIL rd_araddr: got %h want 00000020", araddr); else pass_cnt++;
        tick();
        arready = 0;
        chk_cnt++; if ({arvalid, rready} !== 2'b01) $display("FAIL rd_c2: got %b want 01", {arvalid, rready}); else pass_cnt++;
        tick();
        tick();
        rvalid = 1; rdata = 32'h12345678;
        chk_cnt++; if ({rready, s1_done} !== 2'b10) $display("FAIL rd_c4: got %b want 10", {rready, s1_done}); else pass_cnt++;
        tick();
        rvalid = 0; rdata = 32'h0;
        chk_cnt++; if ({s0_done, s1_done, rready} !== 3'b010) $display("FAIL rd_c5: got %b want 010", {s0_done, s1_done, rready}); else pass_cnt++;
        chk_cnt++; if (s1_rdata !== 32'h12345678) $display("FAIL rd_rdata: got %h want 12345678", s1_rdata); else pass_cnt++;
        chk_cnt++; if (s0_rdata !== 32'h0) $display("FAIL rd_s0_rdata: got %h want 0", s0_rdata); else pass_cnt++;
        tick();
        chk_cnt++; if (s1_done !== 1'b0) $display("FAIL rd_c6: got %b want 0", s1_done); else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_rvalid_idle();
        rvalid = 1; rdata = 32'hFFFF0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cnt++; if ({rready, s0_done, s1_done} !== 3'b000) $display("FAIL ri_c%0d: got %b want 000", i, {rready, s0_done, s1_done}); else pass_cnt++;
            chk_cnt++; if (s1_rdata !== 32'h12345678) $display("FAIL ri_rdata%0d: got %h want 12345678", i, s1_rdata); else pass_cnt++;
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        int order[$];
        int n0 = 0;
        int n1 = 0;
        int exp_order[4] = '{0, 1, 0, 1};
        awready = 1; wready = 1;
        s0_cmd_write = 1; s1_cmd_write = 1;
        for (int cyc = 0; cyc < 60 && order.size() < 4; cyc++) begin
            s0_cmd_valid = (n0 < 2); s0_cmd_addr = 32'h100 + n0;
            s1_cmd_valid = (n1 < 2); s1_cmd_addr = 32'h200 + n1;
            #1;
            if ((s0_cmd_ready || s1_cmd_ready) && (awvalid || wvalid)) begin
                chk_cnt++;
                $display("FAIL bb_overlap: got grant while busy at cycle %0d, want none", cyc);
            end
            if (s0_cmd_ready && s1_cmd_ready) begin
                chk_cnt++;
                $display("FAIL bb_dual_grant: got both ready at cycle %0d, want one", cyc);
            end
            if (s0_cmd_ready) begin order.push_back(0); n0++; end
            else if (s1_cmd_ready) begin order.push_back(1); n1++; end
            @(posedge ACLK);
            #1;
        end
        s0_cmd_valid = 0; s1_cmd_valid = 0;
        chk_cnt++; if (order.size() != 4) $display("FAIL bb_count: got %0d grants want 4", order.size()); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            int got;
            got = (i < order.size()) ? order[i] : -1;
            chk_cnt++; if (got != exp_order[i]) $display("FAIL bb_order%0d: got s%0d want s%0d", i, got, exp_order[i]); else pass_cnt++;
        end
        tick(); tick(); tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        s0_cmd_valid = 1; s0_cmd_write = 1; s0_cmd_addr = 32'h30; s0_cmd_wdata = 32'h5555; s0_cmd_wstrb = 4'hF;
        #1;
        chk_cnt++; if (s0_cmd_ready !== 1'b1) $display("FAIL rm_ready0: got %b want 1", s0_cmd_ready); else pass_cnt++;
        tick();
        s0_cmd_valid = 0;
        s1_cmd_valid = 1; s1_cmd_write = 0; s1_cmd_addr = 32'h88;
        chk_cnt++; if ({awvalid, wvalid} !== 2'b11) $display("FAIL rm_valids: got %b want 11", {awvalid, wvalid}); else pass_cnt++;
        tick();
        chk_cnt++; if (s1_cmd_ready !== 1'b0) $display("FAIL rm_busy_ready: got %b want 0", s1_cmd_ready); else pass_cnt++;
        #2;
        ARESET = 1;
        #1;
        chk_cnt++; if ({awvalid, wvalid, s0_done} !== 3'b000) $display("FAIL rm_async: got %b want 000", {awvalid, wvalid, s0_done}); else pass_cnt++;
        chk_cnt++; if (awaddr !== 32'h0) $display("FAIL rm_awaddr: got %h want 0", awaddr); else pass_cnt++;
        @(posedge ACLK);
        #1;
        ARESET = 0;
        #1;
        chk_cnt++; if ({s1_cmd_ready, s0_done} !== 2'b10) $display("FAIL rm_resume: got %b want 10", {s1_cmd_ready, s0_done}); else pass_cnt++;
        tick();
        s1_cmd_valid = 0; arready = 1;
        chk_cnt++; if ({arvalid, araddr} !== {1'b1, 32'h88}) $display("FAIL rm_ar: got %h want 100000088", {arvalid, araddr}); else pass_cnt++;
        tick();
        arready = 0; rvalid = 1; rdata = 32'hA5A5;
        chk_cnt++; if (rready !== 1'b1) $display("FAIL rm_rready: got %b want 1", rready); else pass_cnt++;
        tick();
        rvalid = 0;
        chk_cnt++; if ({s0_done, s1_done, s1_rdata} !== {2'b01, 32'hA5A5}) $display("FAIL rm_done: got %h want 10000a5a5", {s0_done, s1_done, s1_rdata}); else pass_cnt++;
        tick();
        clear_inputs();
    endtask

    // Randomized traffic; the model tracks each command as an abstract transaction with pending channels.
    task automatic test_random();
        cmd_t        q0[$];
        cmd_t        q1[$];
        cmd_t        cur;
        cmd_t        c;
        bit          busy, own, lastg, awp, wp, arp, v0, v1, granted, win;
        bit [1:0]    dexp;
        logic [31:0] rexp[2];
        int          cyc;
        for (int i = 0; i < 20; i++) begin
            c.wr = 1'($urandom_range(1)); c.addr = $urandom; c.data = $urandom; c.strb = 4'($urandom_range(15));
            q0.push_back(c);
            c.wr = 1'($urandom_range(1)); c.addr = $urandom; c.data = $urandom; c.strb = 4'($urandom_range(15));
            q1.push_back(c);
        end
        clear_inputs();
        ARESET = 1;
        tick();
        ARESET = 0;
        busy = 0; own = 0; lastg = 1; awp = 0; wp = 0; arp = 0; dexp = 0;
        rexp[0] = 0; rexp[1] = 0; cur = '0;
        for (cyc = 0; cyc < 4000; cyc++) begin
            chk_cnt++; if ({s1_done, s0_done} !== dexp) $display("FAIL rnd_done c%0d: got %b want %b", cyc, {s1_done, s0_done}, dexp); else pass_cnt++;
            chk_cnt++; if ({s0_rdata, s1_rdata} !== {rexp[0], rexp[1]}) $display("FAIL rnd_rdata c%0d: got %h want %h", cyc, {s0_rdata, s1_rdata}, {rexp[0], rexp[1]}); else pass_cnt++;
            chk_cnt++;
            if ({awvalid, wvalid, arvalid, rready} !== {busy && cur.wr && awp, busy && cur.wr && wp, busy && !cur.wr && arp, busy && !cur.wr && !arp})
                $display("FAIL rnd_valids c%0d: got %b want %b", cyc, {awvalid, wvalid, arvalid, rready},
                         {busy && cur.wr && awp, busy && cur.wr && wp, busy && !cur.wr && arp, busy && !cur.wr && !arp});
            else pass_cnt++;
            if (busy && cur.wr) begin
                chk_cnt++; if ({awaddr, wdata, wstrb} !== {cur.addr, cur.data, cur.strb}) $display("FAIL rnd_wbus c%0d: got %h want %h", cyc, {awaddr, wdata, wstrb}, {cur.addr, cur.data, cur.strb}); else pass_cnt++;
            end
            if (busy && !cur.wr) begin
                chk_cnt++; if (araddr !== cur.addr) $display("FAIL rnd_araddr c%0d: got %h want %h", cyc, araddr, cur.addr); else pass_cnt++;
            end
            dexp = 0;
            if (q0.size() == 0 && q1.size() == 0 && !busy) break;

            v0 = (q0.size() > 0) && ($urandom_range(3) != 0);
            v1 = (q1.size() > 0) && ($urandom_range(3) != 0);
            s0_cmd_valid = v0;
            if (v0) {s0_cmd_write, s0_cmd_addr, s0_cmd_wdata, s0_cmd_wstrb} = q0[0];
            else    {s0_cmd_write, s0_cmd_addr, s0_cmd_wdata, s0_cmd_wstrb} = {1'($urandom_range(1)), $urandom, $urandom, 4'($urandom_range(15))};
            s1_cmd_valid = v1;
            if (v1) {s1_cmd_write, s1_cmd_addr, s1_cmd_wdata, s1_cmd_wstrb} = q1[0];
            else    {s1_cmd_write, s1_cmd_addr, s1_cmd_wdata, s1_cmd_wstrb} = {1'($urandom_range(1)), $urandom, $urandom, 4'($urandom_range(15))};
            awready = 1'($urandom_range(1)); wready = 1'($urandom_range(1));
            arready = 1'($urandom_range(1)); rvalid = 1'($urandom_range(1)); rdata = $urandom;
            #1;

            granted = !busy && (v0 || v1);
            win     = (v0 && v1) ? !lastg : v1;
            chk_cnt++; if ({s0_cmd_ready, s1_cmd_ready} !== {granted && !win, granted && win}) $display("FAIL rnd_grant c%0d: got %b want %b", cyc, {s0_cmd_ready, s1_cmd_ready}, {granted && !win, granted && win}); else pass_cnt++;

            if (busy && cur.wr) begin
                if (awp && awready) awp = 0;
                if (wp && wready) wp = 0;
                if (!awp && !wp) begin dexp[own] = 1; busy = 0; end
            end else if (busy) begin
                if (arp) begin
                    if (arready) arp = 0;
                end else if (rvalid) begin
                    rexp[own] = rdata; dexp[own] = 1; busy = 0;
                end
            end else if (granted) begin
                busy = 1; own = win; lastg = win;
                cur = win ? q1.pop_front() : q0.pop_front();
                awp = cur.wr; wp = cur.wr; arp = !cur.wr;
            end
            @(posedge ACLK);
            #1;
        end
        chk_cnt++; if (cyc >= 4000) $display("FAIL rnd_timeout: got %0d+%0d commands left want 0", q0.size(), q1.size()); else pass_cnt++;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_split();
        test_read();
        test_rvalid_idle();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
